// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state encodings, reset PC, NOP word.
// Pure declarations, no logic.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;

    typedef logic [1:0] state_t;

    localparam state_t S_REQ  = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_HOLD = 2'd2;
    localparam state_t S_HALT = 2'd3;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: loads RESET_PC on reset, redirect target on load, else +4 on incr.
// One-cycle update latency; no flow control of its own.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            incr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (incr_i) begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: REQ->WAIT->HOLD loop, one outstanding request, registered inst buffer; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect halt.
// Three cycles per instruction at zero-wait memory; stalls in REQ on imem_req_ready and in HOLD on inst_ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pcplus4,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] RESET_PCPLUS4 = RESET_PC + 32'd4;

    state_t          state_q, state_d;
    logic            drop_q, drop_d;
    logic            stale_q, stale_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] data_q, pc_buf_q, pcplus4_buf_q;
    logic            capture;
    logic            pc_load, pc_incr;
    logic [XLEN-1:0] pc, pc_plus4;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            active, redir, trap, rsp_live;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target   = redirect_target;
    assign misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    assign target   = redirect_target & ~32'h0000_0003;
    assign misalign = 1'b0;
`endif

    assign active   = (state_q != S_HALT);
    assign redir    = redirect_valid && active && !misalign;
    assign trap     = misalign && active;
    // A response owed from before a reset or trap is swallowed before any new one counts.
    assign rsp_live = imem_rsp_valid && !stale_q;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        stale_d = stale_q && !imem_rsp_valid;
        err_d   = err_q || trap;
        capture = 1'b0;
        pc_load = 1'b0;
        pc_incr = 1'b0;
        if (trap) begin
            state_d = S_HALT;
            if ((state_q == S_REQ && imem_req_ready) || (state_q == S_WAIT && !rsp_live)) begin
                stale_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    pc_load = redir;
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = redir;
                    end
                end
                S_WAIT: begin
                    if (rsp_live) begin
                        if (drop_q || redir) begin
                            state_d = S_REQ;
                            drop_d  = 1'b0;
                            pc_load = redir;
                        end else begin
                            capture = 1'b1;
                            state_d = S_HOLD;
                        end
                    end else if (redir) begin
                        drop_d  = 1'b1;
                        pc_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        pc_load = 1'b1;
                        state_d = S_REQ;
                    end else if (inst_ready) begin
                        pc_incr = 1'b1;
                        state_d = S_REQ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
            stale_q       <= (state_q == S_WAIT || stale_q) && !imem_rsp_valid;
            data_q        <= NOP_INSN;
            pc_buf_q      <= RESET_PC;
            pcplus4_buf_q <= RESET_PCPLUS4;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            stale_q <= stale_d;
            if (capture) begin
                data_q        <= imem_rsp_data;
                pc_buf_q      <= pc;
                pcplus4_buf_q <= pc_plus4;
            end
        end
    end

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load_i    (pc_load),
        .target_i  (target),
        .incr_i    (pc_incr),
        .pc_o      (pc),
        .pc_plus4_o(pc_plus4)
    );

    assign imem_req_valid = (state_q == S_REQ) && !reset;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst_data      = data_q;
    assign inst_pc        = pc_buf_q;
    assign inst_pcplus4   = pcplus4_buf_q;
    assign misalign_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stalls, redirects, wrap, misalign, reset in flight.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pcplus4;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pcplus4   (inst_pcplus4),
        .misalign_err   (misalign_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        inst_ready      = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        tests++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        tests++; if (inst_data !== 32'h0000_0013) begin fails++; $display("FAIL reset_nop: got %h want 00000013", inst_data); end
        reset = 1'b0;
        #1;
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_first_req: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
        apply_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc   = 32'(i) * 32'd4;
            exp_data = 32'h1000_0000 + 32'(i);
            tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin fails++; $display("FAIL stream_req%0d: got %b/%h want 1/%h", i, imem_req_valid, imem_req_addr, exp_pc); end
            tick();
            tests++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL stream_wait%0d: got req %b inst %b want 0/0", i, imem_req_valid, inst_valid); end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = exp_data;
            tick();
            imem_rsp_valid = 1'b0;
            tests++; if (inst_valid !== 1'b1 || inst_data !== exp_data || inst_pc !== exp_pc) begin fails++; $display("FAIL stream_hold%0d: got %b %h %h want 1 %h %h", i, inst_valid, inst_data, inst_pc, exp_data, exp_pc); end
            tests++; if (inst_pcplus4 !== exp_pc + 32'd4) begin fails++; $display("FAIL stream_pcplus4_%0d: got %h want %h", i, inst_pcplus4, exp_pc + 32'd4); end
            tick();
            tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL stream_drop_valid%0d: got %b want 0", i, inst_valid); end
        end
        idle_inputs();
    endtask

    task automatic test_req_stall;
        apply_reset();
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0011;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin fails++; $display("FAIL stall_hold_addr%0d: got %b/%h want 1/00000004", k, imem_req_valid, imem_req_addr); end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_single_req: got %b want 0", imem_req_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0044;
        inst_ready     = 1'b0;
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_pc !== 32'h4 || inst_data !== 32'h44) begin fails++; $display("FAIL stall_word: got %h/%h want 00000004/00000044", inst_pc, inst_data); end
        idle_inputs();
    endtask

    task automatic test_redirect_wait;
        apply_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        tests++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL redir_wait_stay: got req %b inst %b want 0/0", imem_req_valid, inst_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_wait_discard: got %b want 0", inst_valid); end
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin fails++; $display("FAIL redir_wait_next: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_1234;
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h1234 || inst_pc !== 32'h100) begin fails++; $display("FAIL redir_wait_word: got %b %h %h want 1 00001234 00000100", inst_valid, inst_data, inst_pc); end
        idle_inputs();
    endtask

    task automatic test_redirect_req;
        apply_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        tick();
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin fails++; $display("FAIL redir_req_noready: got %b/%h want 1/00000040", imem_req_valid, imem_req_addr); end
        redirect_target = 32'h0000_0080;
        imem_req_ready  = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_req_issued: got %b want 0", imem_req_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_AAAA;
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin fails++; $display("FAIL redir_req_ready: got %b %b %h want 0 1 00000080", inst_valid, imem_req_valid, imem_req_addr); end
        idle_inputs();
    endtask

    task automatic test_hold_stall;
        apply_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_5555;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hFFFF_0000;
        for (int k = 0; k < 4; k++) begin
            tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h5555 || inst_pc !== 32'h0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL hold_stable%0d: got %b %h %h req %b want 1 00005555 00000000 0", k, inst_valid, inst_data, inst_pc, imem_req_valid); end
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin fails++; $display("FAIL hold_release: got %b %b %h want 0 1 00000004", inst_valid, imem_req_valid, imem_req_addr); end
        idle_inputs();
    endtask

    task automatic test_wrap_and_hold_redirect;
        apply_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0077;
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_pc !== 32'hFFFF_FFFC || inst_pcplus4 !== 32'h0) begin fails++; $display("FAIL wrap_pcplus4: got %h/%h want fffffffc/00000000", inst_pc, inst_pcplus4); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL wrap_next: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0088;
        tick();
        imem_rsp_valid  = 1'b0;
        inst_ready      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin fails++; $display("FAIL hold_redirect: got %b %b %h want 0 1 00000200", inst_valid, imem_req_valid, imem_req_addr); end
        idle_inputs();
    endtask

    task automatic test_misalign;
        apply_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        tests++; if (misalign_err !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL misalign_halt: got err %b req %b inst %b want 1 0 0", misalign_err, imem_req_valid, inst_valid); end
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0300;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (misalign_err !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL misalign_stuck%0d: got err %b req %b want 1 0", k, misalign_err, imem_req_valid); end
        end
        apply_reset();
        tests++; if (misalign_err !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL misalign_reset: got err %b req %b %h want 0 1 00000000", misalign_err, imem_req_valid, imem_req_addr); end
`else
        tests++; if (misalign_err !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin fails++; $display("FAIL misalign_forced: got err %b req %b %h want 0 1 00000100", misalign_err, imem_req_valid, imem_req_addr); end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_in_wait;
        apply_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        #1;
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL rst_wait_first_req: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin fails++; $display("FAIL rst_wait_ignored: got inst %b req %b want 0 1", inst_valid, imem_req_valid); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_600D;
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h600D) begin fails++; $display("FAIL rst_wait_next_word: got %b %h want 1 0000600d", inst_valid, inst_data); end

        // late stale response landing after a new request was issued
        apply_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD1_BAD1;
        tick();
        tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_stale_swallow: got inst %b req %b want 0 0", inst_valid, imem_req_valid); end
        imem_rsp_data = 32'h0000_600E;
        tick();
        imem_rsp_valid = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h600E || inst_pc !== 32'h0) begin fails++; $display("FAIL rst_stale_real: got %b %h %h want 1 0000600e 00000000", inst_valid, inst_data, inst_pc); end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_req_stall();
        test_redirect_wait();
        test_redirect_req();
        test_hold_stall();
        test_wrap_and_hold_redirect();
        test_misalign();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: imem_req_valid  output  1  fetch request valid.
REQ-005 Port: imem_req_addr  output  32  fetch address (current PC).
REQ-006 Port: imem_req_ready  input  1  memory accepts request.
REQ-007 Port: imem_rsp_valid  input  1  instruction word returned.
REQ-008 Port: imem_rsp_data  input  32  returned instruction word.
REQ-009 Port: redirect_valid  input  1  taken branch/jump (PCSrc) from execute.
REQ-010 Port: redirect_target  input  32  branch/jump target (PCTarget).
REQ-011 Port: inst_valid  output  1  buffered instruction available to decode.
REQ-012 Port: inst_ready  input  1  decode/control consumes instruction.
REQ-013 Port: inst_data, inst_pc, inst_pcplus4  output  32 each  instruction, its PC, PC+4.
REQ-014 Port: misalign_err  output  1  sticky misaligned-target flag.

Function
REQ-015 FSM states REQ, WAIT, HOLD, HALT; one outstanding memory request maximum.
REQ-016 REQ: imem_req_valid=1, imem_req_addr=PC; on imem_req_ready go to WAIT.
REQ-017 WAIT: on imem_rsp_valid capture data, PC, PC+4 into buffer; go to HOLD; inst_valid rises the following cycle (registered, no combinational rsp->inst path).
REQ-018 HOLD: inst_valid=1, buffer stable; on inst_ready go to REQ with PC=PC+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-019 Minimum throughput one instruction per 3 cycles with zero-wait memory.
REQ-020 Redirect in REQ without imem_req_ready: PC=target next cycle, remain REQ.
REQ-021 Redirect in REQ with imem_req_ready same cycle: request counts as issued; go WAIT with drop flag set; dropped response discarded, then REQ at target.
REQ-022 Redirect in WAIT: set drop flag, PC=target; response discarded (inst_valid stays 0); then REQ.
REQ-023 Redirect in HOLD: buffer invalidated, PC=target, go REQ; if inst_ready also high that cycle the handshake completes (consumer keeps word) but PC+4 is not used.
REQ-024 imem_rsp_valid in REQ or HOLD ignored.
REQ-025 inst_pcplus4 equals inst_pc+4 truncated to 32 bits.

Reset
REQ-026 While reset=1 (sampled at edge): PC=RESET_PC, state=REQ, drop flag=0, buffer cleared to NOP 32'h0000_0013, inst_valid=0, misalign_err=0.
REQ-027 imem_req_valid=0 while reset high; first request in first cycle after reset deasserts.
REQ-028 Reset mid-operation abandons any outstanding request; its late response ignored (drop flag set on exit if request was in flight).

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN: defined -> redirect_target[1:0]!=0 sets misalign_err, enters HALT (imem_req_valid=0, inst_valid=0) until reset.
REQ-030 Undefined -> redirect_target[1:0] forced to 2'b00, misalign_err tied 0, HALT unreachable.

Structure
REQ-031 Shared package fetch_pkg holds state enum, RESET_PC default, NOP constant, XLEN=32.
REQ-032 One sub-module fetch_pc_reg: PC register with reset load, +4 increment, redirect mux.

Verification
REQ-033 Reset release, zero-wait memory, inst_ready=1 -> requests at 0x0, 0x4, 0x8, one inst_valid per 3 cycles, inst_pcplus4 correct.
REQ-034 imem_req_ready low 5 cycles -> address held at 0x4, single request issued on ready.
REQ-035 Redirect to 0x100 in WAIT, response 0xDEADBEEF -> word discarded, next request 0x100, no inst_valid for 0xDEADBEEF.
REQ-036 inst_ready low 4 cycles in HOLD -> inst_data/inst_pc stable; no new request until handshake.
REQ-037 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err=1, HALT, no requests until reset; without macro next request 0x100.
REQ-038 Reset asserted in WAIT, response next cycle -> ignored; first post-reset request at RESET_PC.
